mem_store_buffer_unit: RTL and testbench

- Memory-side responder for the single-cycle MIPS core: serves the instruction-fetch port and the data load/store port, using the same signal names as the core.
- The backing word array has a multi-cycle write latency (WR_LAT). Stores are posted into a FIFO store buffer and drained by an FSM.
- Loads are combinational, with youngest-match forwarding from the buffer. A stall output tells the core when a store cannot be accepted.

---
 rtl/mem_store_buffer_unit_pkg.sv | 24 ++
 rtl/mem_store_buffer_unit_store_fifo.sv | 85 ++++++++
 rtl/mem_store_buffer_unit.sv | 117 +++++++++++
 tb/tb_mem_store_buffer_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_buffer_unit_pkg.sv
// Shared definitions for the MIPS memory responder with a posted-store buffer.
// Provides the drain FSM state encoding, store-buffer entry field widths and
// the byte-address to word-index helper used by the fetch, load and store paths.
package mem_store_buffer_unit_pkg;

  // Width of a data word and of a core byte address
  localparam int DATA_W      = 32;
  localparam int BYTE_ADDR_W = 32;
  // A word index before truncation to the array depth
  localparam int WORD_ADDR_W = BYTE_ADDR_W - 2;

  // Drain FSM states: IDLE waits for work, BUSY models the array write latency
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } drain_state_t;

  // Drops the byte offset. Callers truncate the result to their array depth,
  // which makes upper address bits alias (wrap) onto the array.
  function automatic logic [WORD_ADDR_W-1:0] word_index(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return WORD_ADDR_W'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/mem_store_buffer_unit_store_fifo.sv
// Circular FIFO of posted stores, each entry {word index, data}.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   push, push_idx/data enqueue one store at the tail
//   pop                 drop the head entry
//   head_idx/head_data  oldest entry, the one being drained
//   count, full         occupancy (0..SB_DEPTH) and full flag
//   search_idx          combinational lookup key
//   hit, hit_data       youngest valid entry whose index matches search_idx
module store_fifo
  import mem_store_buffer_unit_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_idx,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head_idx,
  output logic [DATA_W-1:0]              head_data,
  output logic [$clog2(SB_DEPTH+1)-1:0]  count,
  output logic                           full,
  input  logic [ADDR_W-1:0]              search_idx,
  output logic                           hit,
  output logic [DATA_W-1:0]              hit_data
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH+1);

  logic [ADDR_W-1:0] idx_q  [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointers wrap naturally because SB_DEPTH is a power of two. When full and
  // popping on the same edge, wr_ptr equals rd_ptr, so the new entry reuses the
  // slot being freed and the count stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; validity comes only from the pointers and count
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      idx_q[wr_ptr]  <= push_idx;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_idx  = idx_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign full      = (count == CNT_W'(SB_DEPTH));

  // Walk from oldest to youngest so that a later match overrides an earlier one
  always_comb begin
    logic [PTR_W-1:0] pos;
    hit      = 1'b0;
    hit_data = '0;
    pos      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      pos = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (idx_q[pos] == search_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[pos];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer_unit.sv
// Memory-side responder for the single-cycle MIPS core. Serves the fetch port
// and the load/store port from one word array whose writes take WR_LAT cycles.
// Stores are posted into a store buffer and drained one at a time; loads see
// the youngest buffered store to the same word before falling back to the array.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   inst_addr    fetch byte address; instr returns the array word (no forwarding)
//   data_addr    load/store byte address
//   data_in      store data
//   mem_read     load request; data_out is zero when low
//   mem_write    store request; held by the core while stall is high
//   data_out     load data, combinational
//   stall        store cannot be accepted this cycle
//   sb_empty     buffer empty and no drain in progress
module mem_store_buffer_unit
  import mem_store_buffer_unit_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4,
  parameter int WR_LAT   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       instr,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_in,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [31:0]       data_out,
  output logic              stall,
  output logic              sb_empty
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_W    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam int SB_CNT_W = $clog2(SB_DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]   inst_idx;
  logic [ADDR_W-1:0]   data_idx;
  logic                push;
  logic                pop;
  logic [ADDR_W-1:0]   head_idx;
  logic [DATA_W-1:0]   head_data;
  logic [SB_CNT_W-1:0] sb_count;
  logic                sb_full;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  drain_state_t        state;
  logic [CNT_W-1:0]    cnt;

  assign inst_idx = ADDR_W'(word_index(inst_addr));
  assign data_idx = ADDR_W'(word_index(data_addr));

  // The head leaves the buffer on the last BUSY cycle, which is also the cycle
  // a full buffer can take a new store without stalling.
  assign pop   = (state == ST_BUSY) && (cnt == '0);
  assign stall = mem_write & sb_full & ~pop;
  assign push  = mem_write & ~stall;

  store_fifo #(
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_store_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_idx   (data_idx),
    .push_data  (data_in),
    .pop        (pop),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .count      (sb_count),
    .full       (sb_full),
    .search_idx (data_idx),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  // Drain FSM: IDLE spends one cycle noticing work, BUSY counts down the write
  // latency with the head still in the buffer so loads keep forwarding from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sb_count != '0) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(WR_LAT - 1);
          end
        end
        ST_BUSY: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The array is never reset; a drain interrupted by reset must not land
  always_ff @(posedge clk) begin
    if (pop && !reset) mem[head_idx] <= head_data;
  end

  assign instr    = mem[inst_idx];
  assign data_out = !mem_read ? '0 : (fwd_hit ? fwd_data : mem[data_idx]);
  assign sb_empty = (sb_count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_mem_store_buffer_unit.sv
// Self-checking bench for mem_store_buffer_unit. The reference model is an
// architectural memory: every accepted store updates it at once, so loads must
// always match it and fetches must match it whenever the buffer reports empty.
module tb_mem_store_buffer_unit;

  localparam int ADDR_W   = 8;
  localparam int SB_DEPTH = 4;
  localparam int WR_LAT   = 3;
  localparam int DEPTH    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;
  logic        stall;
  logic        sb_empty;

  logic [31:0] ref_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_store_buffer_unit #(
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH),
    .WR_LAT   (WR_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_addr (inst_addr),
    .instr     (instr),
    .data_addr (data_addr),
    .data_in   (data_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_out  (data_out),
    .stall     (stall),
    .sb_empty  (sb_empty)
  );

  // The core never loads and stores in the same cycle
  always @(negedge clk) begin
    assert (!(mem_read && mem_write))
      else $fatal(1, "[TB] FAIL rd_wr_overlap: mem_read and mem_write both high");
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] da,
                               input logic [31:0] dd, input logic [31:0] ia);
    mem_read  = rd;
    mem_write = wr;
    data_addr = da;
    data_in   = dd;
    inst_addr = ia;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a store and hold it while stalled, up to a bounded number of cycles
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int waited;
    waited = 0;
    applyStimulus(1'b0, 1'b1, a, d, 32'h0);
    @(negedge clk);
    while (stall === 1'b1 && waited < 64) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    checkOutput("store_accept", 32'(stall), 32'h0);
    if (stall === 1'b0) ref_mem[widx(a)] = d;
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    while (sb_empty !== 1'b1 && n < 200) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 32'(sb_empty), 32'h1);
    next_cycle();
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] ia;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        pend;
    int          op;
    int          stall_run;

    // Reset and idle outputs
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_sb_empty", 32'(sb_empty), 32'h1);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_data_out", data_out, 32'h0);
    next_cycle();

    // Give every array word a known value through the store port
    $display("[TB] filling array");
    for (int i = 0; i < DEPTH; i++) do_store(32'(i * 4), 32'h5A5A_0000 + 32'(i));
    wait_empty();

    // Forwarding one cycle after the store; fetch sees it only after the drain
    $display("[TB] forwarding and fetch timing");
    old = ref_mem[widx(32'h40)];
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h40);
    @(negedge clk);
    checkOutput("t_stall", 32'(stall), 32'h0);
    checkOutput("t_fetch_old", instr, old);
    ref_mem[widx(32'h40)] = 32'hDEAD_BEEF;
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'h40);
    @(negedge clk);
    checkOutput("t1_load_fwd", data_out, 32'hDEAD_BEEF);
    checkOutput("t1_fetch_old", instr, old);
    next_cycle();
    for (int k = 2; k <= WR_LAT + 1; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
      @(negedge clk);
      checkOutput("drain_fetch_old", instr, old);
      checkOutput("drain_not_empty", 32'(sb_empty), 32'h0);
      next_cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
    @(negedge clk);
    checkOutput("fetch_new", instr, 32'hDEAD_BEEF);
    checkOutput("empty_again", 32'(sb_empty), 32'h1);
    next_cycle();

    // Same-word stores: youngest forwards, last one wins in the array
    $display("[TB] same-index ordering");
    do_store(32'h80, 32'h11);
    do_store(32'h80, 32'h22);
    do_store(32'h80, 32'h33);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("youngest_fwd", data_out, 32'h33);
    next_cycle();
    wait_empty();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 32'h80);
    @(negedge clk);
    checkOutput("last_wins_load", data_out, 32'h33);
    checkOutput("last_wins_fetch", instr, 32'h33);
    next_cycle();

    // Full buffer: the fifth store lands on the first pop cycle and is taken;
    // the sixth waits through the next IDLE plus BUSY until the second pop.
    $display("[TB] full buffer and stall");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'hC000_0000 + 32'(k), 32'h0);
      @(negedge clk);
      checkOutput("burst_no_stall", 32'(stall), 32'h0);
      if (stall === 1'b0) ref_mem[widx(32'h100 + 32'(4 * k))] = 32'hC000_0000 + 32'(k);
      next_cycle();
    end
    for (int k = 0; k < WR_LAT; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h114, 32'hC000_0005, 32'h0);
      @(negedge clk);
      checkOutput("sixth_stall", 32'(stall), 32'h1);
      next_cycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h114, 32'hC000_0005, 32'h0);
    @(negedge clk);
    checkOutput("sixth_accept", 32'(stall), 32'h0);
    if (stall === 1'b0) ref_mem[widx(32'h114)] = 32'hC000_0005;
    next_cycle();
    wait_empty();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 32'h100 + 32'(4 * k));
      @(negedge clk);
      checkOutput("burst_load", data_out, 32'hC000_0000 + 32'(k));
      checkOutput("burst_fetch", instr, 32'hC000_0000 + 32'(k));
      next_cycle();
    end

    // Reset on the cycle the write would commit: entry dropped, array untouched
    $display("[TB] reset during drain");
    old = ref_mem[widx(32'hC0)];
    applyStimulus(1'b0, 1'b1, 32'hC0, 32'hBAD0_BAD0, 32'h0);
    @(negedge clk);
    checkOutput("rst_store_accept", 32'(stall), 32'h0);
    next_cycle();
    for (int k = 1; k <= WR_LAT; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'hC0, 32'h0, 32'hC0);
    @(negedge clk);
    checkOutput("rst_sb_empty", 32'(sb_empty), 32'h1);
    checkOutput("rst_load_old", data_out, old);
    checkOutput("rst_fetch_old", instr, old);
    next_cycle();
    repeat (WR_LAT + 2) next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'hC0);
    @(negedge clk);
    checkOutput("rst_fetch_still_old", instr, old);
    next_cycle();

    // Upper address bits and byte offset are ignored
    $display("[TB] address aliasing");
    do_store(32'h400, 32'h0A11_A500);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("alias_load_0", data_out, 32'h0A11_A500);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h3, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("alias_load_3", data_out, 32'h0A11_A500);
    next_cycle();
    wait_empty();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FC02);
    @(negedge clk);
    checkOutput("alias_fetch", instr, 32'h0A11_A500);
    next_cycle();

    // Random load/store mix over a small set of words to exercise forwarding
    $display("[TB] random mix");
    pend      = 1'b0;
    pa        = 32'h0;
    pd        = 32'h0;
    stall_run = 0;
    for (int c = 0; c < 800; c++) begin
      op = 0;
      r  = $urandom;
      a  = (r & 32'hFFFF_FC03) | {24'b0, r[7:4], 2'b00};
      r  = $urandom;
      ia = (r & 32'hFFFF_FC03) | {24'b0, r[7:4], 2'b00};
      if (!pend) begin
        op = $urandom_range(0, 2);
        if (op == 2) begin
          pend = 1'b1;
          pa   = a;
          pd   = $urandom;
        end
      end
      if (pend)         applyStimulus(1'b0, 1'b1, pa, pd, ia);
      else if (op == 1) applyStimulus(1'b1, 1'b0, a, 32'h0, ia);
      else              applyStimulus(1'b0, 1'b0, a, 32'h0, ia);
      @(negedge clk);
      if (op == 1) checkOutput("rand_load", data_out, ref_mem[widx(a)]);
      if (sb_empty === 1'b1) checkOutput("rand_fetch", instr, ref_mem[widx(ia)]);
      if (pend && stall === 1'b0) begin
        ref_mem[widx(pa)] = pd;
        pend = 1'b0;
        stall_run = 0;
      end else if (pend) begin
        stall_run++;
        if (stall_run >= 32) begin
          checkOutput("rand_stall_bound", 32'(stall_run), 32'h0);
          pend = 1'b0;
          stall_run = 0;
        end
      end
      next_cycle();
    end
    wait_empty();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b0, 32'(4 * k), 32'h0, 32'(4 * k));
      @(negedge clk);
      checkOutput("final_load", data_out, ref_mem[k]);
      checkOutput("final_fetch", instr, ref_mem[k]);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
